// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : data_sram_resp
//  Purpose  : Word-addressed SRAM with byte-lane writes, one-cycle registered
//             reads, power-up/reset self-clear and sticky out-of-range flag.
//  Revision : 1.0  initial release
// ============================================================================
module data_sram_resp #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        rdata_valid,
   output logic        init_busy,
   output logic        addr_err
);

   localparam int              c_depth = 2 ** ADDR_W;
   localparam logic [31:0]     c_span  = 32'(4 * c_depth);
   localparam logic [ADDR_W-1:0] c_last = {ADDR_W{1'b1}};

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   logic [31:0]       r_mem [c_depth];
   logic [31:0]       r_rdata;
   logic              r_rdata_valid;
   logic              r_addr_err;

   logic [31:0]       w_offset;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_index;
   logic [3:0]        w_mem_we;
   logic [ADDR_W-1:0] w_mem_idx;
   logic [31:0]       w_mem_wdata;
   logic              w_rd_accept;
   logic              w_err_set;

   // Offset wraps for addresses below BASE_ADDR, so one unsigned compare
   // rejects both ends of the window.
   assign w_offset   = data_sram_addr - BASE_ADDR;
   assign w_in_range = (w_offset < c_span);
   assign w_index    = w_offset[ADDR_W+1:2];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mem_we    = 4'h0;
      w_mem_idx   = w_index;
      w_mem_wdata = data_sram_wdata;
      w_rd_accept = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_mem_we    = 4'hF;
            w_mem_idx   = r_cnt;
            w_mem_wdata = 32'h0;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == c_last) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            if (data_sram_en) begin
               w_err_set = ~w_in_range;
               if (data_sram_we == 4'h0) begin
                  w_rd_accept = 1'b1;
               end else if (w_in_range) begin
                  w_mem_we = data_sram_we;
               end
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
      // A request sharing the cycle with reset must not touch memory.
      if (reset) begin
         w_mem_we = 4'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_mem_we[i]) begin
            r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata       <= 32'h0;
         r_rdata_valid <= 1'b0;
         r_addr_err    <= 1'b0;
      end else begin
         r_rdata_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rdata <= w_in_range ? r_mem[w_index] : 32'h0;
         end
         if (w_err_set) begin
            r_addr_err <= 1'b1;
         end
      end
   end

   assign data_sram_rdata = r_rdata;
   assign rdata_valid     = r_rdata_valid;
   assign addr_err        = r_addr_err;
   assign init_busy       = (r_state == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_sram_resp
//  Purpose  : Directed self-checking bench for data_sram_resp (16-word config).
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_sram_resp;

   localparam logic [31:0] c_base = 32'h1c00_0000;

   logic        clk;
   logic        reset;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        rdata_valid;
   logic        init_busy;
   logic        addr_err;

   int total;
   int bad;
   int busy_cycles;
   logic saw_valid;
   logic saw_err;

   data_sram_resp #(
      .ADDR_W    (4),
      .BASE_ADDR (c_base)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .rdata_valid     (rdata_valid),
      .init_busy       (init_busy),
      .addr_err        (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      data_sram_en    = 1'b0;
      data_sram_we    = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      data_sram_en    = 1'b1;
      data_sram_we    = we;
      data_sram_addr  = a;
      data_sram_wdata = d;
      step();
      idle();
   endtask

   task automatic do_read(input logic [31:0] a);
      data_sram_en    = 1'b1;
      data_sram_we    = 4'h0;
      data_sram_addr  = a;
      data_sram_wdata = 32'h0;
      step();
      idle();
   endtask

   // Counts cycles with init_busy high, optionally injecting traffic that
   // must be ignored while the clear runs.
   task automatic count_init(input logic inject);
      busy_cycles = 0;
      saw_valid   = 1'b0;
      saw_err     = 1'b0;
      while (init_busy === 1'b1 && busy_cycles < 40) begin
         busy_cycles++;
         idle();
         if (inject && busy_cycles == 4) begin
            data_sram_en    = 1'b1;
            data_sram_we    = 4'hF;
            data_sram_addr  = c_base;
            data_sram_wdata = 32'hFFFF_FFFF;
         end
         if (inject && busy_cycles == 6) begin
            data_sram_en    = 1'b1;
            data_sram_addr  = c_base + 32'h40;
         end
         if (inject && busy_cycles == 8) begin
            data_sram_en    = 1'b1;
            data_sram_addr  = c_base + 32'h30;
         end
         step();
         if (rdata_valid === 1'b1) saw_valid = 1'b1;
         if (addr_err === 1'b1) saw_err = 1'b1;
      end
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;

      chk("reset_busy",  32'(init_busy),   32'h1);
      chk("reset_rdata", data_sram_rdata,  32'h0);
      chk("reset_valid", 32'(rdata_valid), 32'h0);
      chk("reset_err",   32'(addr_err),    32'h0);

      count_init(1'b1);
      chk("init_len",        32'(busy_cycles), 32'd16);
      chk("init_no_valid",   32'(saw_valid),   32'h0);
      chk("init_no_err",     32'(saw_err),     32'h0);

      do_read(c_base + 32'h30);
      chk("rd30_data",  data_sram_rdata,  32'h0);
      chk("rd30_valid", 32'(rdata_valid), 32'h1);
      step();
      chk("idle_valid", 32'(rdata_valid), 32'h0);

      do_read(c_base);
      chk("init_wr_ignored", data_sram_rdata, 32'h0);
      chk("err_still_0",     32'(addr_err),   32'h0);

      do_write(c_base + 32'h08, 4'hF, 32'hDEAD_BEEF);
      chk("wr_no_valid", 32'(rdata_valid), 32'h0);
      chk("wr_rdata_held", data_sram_rdata, 32'h0);
      do_read(c_base + 32'h08);
      chk("raw_data",  data_sram_rdata,  32'hDEAD_BEEF);
      chk("raw_valid", 32'(rdata_valid), 32'h1);

      do_write(c_base + 32'h08, 4'b0101, 32'h1122_3344);
      do_read(c_base + 32'h08);
      chk("lane_merge", data_sram_rdata, 32'hDE22_BE44);

      data_sram_en    = 1'b0;
      data_sram_we    = 4'hF;
      data_sram_addr  = c_base + 32'h08;
      data_sram_wdata = 32'h0;
      step();
      idle();
      chk("hold_data",  data_sram_rdata,  32'hDE22_BE44);
      chk("hold_valid", 32'(rdata_valid), 32'h0);
      do_read(c_base + 32'h08);
      chk("en0_no_write", data_sram_rdata, 32'hDE22_BE44);

      do_read(c_base + 32'h40);
      chk("oor_data",  data_sram_rdata,  32'h0);
      chk("oor_valid", 32'(rdata_valid), 32'h1);
      chk("oor_err",   32'(addr_err),    32'h1);

      do_write(c_base + 32'h40, 4'hF, 32'hAAAA_5555);
      do_write(c_base - 32'h08, 4'hF, 32'h5555_AAAA);
      do_read(c_base);
      chk("oor_wr_hi_dropped", data_sram_rdata, 32'h0);
      do_read(c_base + 32'h38);
      chk("oor_wr_lo_dropped", data_sram_rdata, 32'h0);
      do_read(c_base + 32'h08);
      chk("err_sticky_data", data_sram_rdata, 32'hDE22_BE44);
      chk("err_sticky",      32'(addr_err),   32'h1);

      do_write(c_base + 32'h08, 4'hF, 32'hDEAD_BEEF);
      do_write(c_base + 32'h3c, 4'hF, 32'hCAFE_F00D);
      do_read(c_base + 32'h3c);
      chk("last_word", data_sram_rdata, 32'hCAFE_F00D);

      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst2_err", 32'(addr_err), 32'h0);
      for (int i = 0; i < 6; i++) step();
      chk("mid_init_busy", 32'(init_busy), 32'h1);

      // Reset again partway through the clear, with a read presented alongside.
      reset           = 1'b1;
      data_sram_en    = 1'b1;
      data_sram_addr  = c_base + 32'h08;
      step();
      reset = 1'b0;
      idle();
      chk("rst_prio_valid", 32'(rdata_valid), 32'h0);
      chk("rst_prio_rdata", data_sram_rdata,  32'h0);

      count_init(1'b0);
      chk("reinit_len", 32'(busy_cycles), 32'd16);
      do_read(c_base + 32'h08);
      chk("reinit_idx2", data_sram_rdata, 32'h0);
      chk("reinit_valid", 32'(rdata_valid), 32'h1);
      do_read(c_base + 32'h3c);
      chk("reinit_idx15", data_sram_rdata, 32'h0);
      chk("reinit_err", 32'(addr_err), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
